// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic-light controller's time-setting path:
// edit FSM encoding, field codes and the BCD limits used by the clock.
package tlc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SET_HH = 3'd1,
    ST_SET_MM = 3'd2,
    ST_SET_SS = 3'd3,
    ST_COMMIT = 3'd4
  } tse_state_t;

  localparam logic [1:0] FIELD_IDLE = 2'd0;
  localparam logic [1:0] FIELD_HH   = 2'd1;
  localparam logic [1:0] FIELD_MM   = 2'd2;
  localparam logic [1:0] FIELD_SS   = 2'd3;

  localparam logic [7:0] BCD_12 = 8'h12;
  localparam logic [7:0] BCD_59 = 8'h59;
  localparam logic [7:0] BCD_01 = 8'h01;
  localparam logic [7:0] BCD_00 = 8'h00;

endpackage

// File: rtl/key_debounce.sv
// Raw push-button conditioning: 2-FF synchroniser, stability counter and a
// one-cycle press pulse on each accepted 0->1 transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  // Any sample agreeing with the accepted level restarts the stability count.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a  <= 1'b0;
      sync_b  <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_a  <= key_raw;
      sync_b  <= sync_a;
      level_q <= level;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_b;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign press = level & ~level_q;

endmodule

// File: rtl/time_set_entry.sv
// Operator time-setting front end: two debounced keys step through the
// hour/minute/second fields of a 12-hour BCD time and pulse load to commit.
module time_set_entry #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 64,
  parameter int BLINK_CYCLES    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic [7:0] hh_in,
  input  logic [7:0] mm_in,
  input  logic [7:0] ss_in,
  input  logic       pm_in,
  output logic [7:0] hh_out,
  output logic [7:0] mm_out,
  output logic [7:0] ss_out,
  output logic       pm_out,
  output logic       load,
  output logic       editing,
  output logic [1:0] field,
  output logic       blink
);
  import tlc_pkg::*;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_CYCLES - 1);

  tse_state_t    state, state_next;
  logic          mode_ev, inc_ev;
  logic [TW-1:0] timeout_cnt;
  logic          timed_out;
  logic [BW-1:0] blink_cnt;
  logic          blink_q;

  function automatic logic [7:0] norm_hour(input logic [7:0] v);
    logic ok;
    ok = ((v[7:4] == 4'd0) && (v[3:0] >= 4'd1) && (v[3:0] <= 4'd9)) ||
         ((v[7:4] == 4'd1) && (v[3:0] <= 4'd2));
    return ok ? v : BCD_12;
  endfunction

  function automatic logic [7:0] norm_60(input logic [7:0] v);
    return ((v[7:4] <= 4'd5) && (v[3:0] <= 4'd9)) ? v : BCD_00;
  endfunction

  function automatic logic [7:0] inc_hour(input logic [7:0] v);
    if (v == BCD_12)         return BCD_01;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                     return v + 8'd1;
  endfunction

  function automatic logic [7:0] inc_60(input logic [7:0] v);
    if (v == BCD_59)         return BCD_00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                     return v + 8'd1;
  endfunction

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_key (
    .clk(clk), .reset(reset), .key_raw(key_mode), .press(mode_ev)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_key (
    .clk(clk), .reset(reset), .key_raw(key_inc), .press(inc_ev)
  );

  assign timed_out = (timeout_cnt == TO_LAST) && !mode_ev && !inc_ev;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    editing    = 1'b0;
    field      = FIELD_IDLE;
    load       = 1'b0;
    case (state)
      ST_IDLE: if (mode_ev) state_next = ST_SET_HH;
      ST_SET_HH: begin
        editing = 1'b1;
        field   = FIELD_HH;
        if (mode_ev)        state_next = ST_SET_MM;
        else if (timed_out) state_next = ST_IDLE;
      end
      ST_SET_MM: begin
        editing = 1'b1;
        field   = FIELD_MM;
        if (mode_ev)        state_next = ST_SET_SS;
        else if (timed_out) state_next = ST_IDLE;
      end
      ST_SET_SS: begin
        editing = 1'b1;
        field   = FIELD_SS;
        if (mode_ev)        state_next = ST_COMMIT;
        else if (timed_out) state_next = ST_IDLE;
      end
      ST_COMMIT: begin
        load       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Mode beats inc in the same cycle, so inc only edits when mode is quiet.
  always_ff @(posedge clk) begin
    if (reset) begin
      hh_out <= BCD_12;
      mm_out <= BCD_00;
      ss_out <= BCD_00;
      pm_out <= 1'b0;
    end else if (state == ST_IDLE && mode_ev) begin
      hh_out <= norm_hour(hh_in);
      mm_out <= norm_60(mm_in);
      ss_out <= norm_60(ss_in);
      pm_out <= pm_in;
    end else if (inc_ev && !mode_ev) begin
      case (state)
        ST_SET_HH: begin
          hh_out <= inc_hour(hh_out);
          if (hh_out == 8'h11) pm_out <= ~pm_out;
        end
        ST_SET_MM: mm_out <= inc_60(mm_out);
        ST_SET_SS: ss_out <= inc_60(ss_out);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      timeout_cnt <= '0;
    else if (!editing || mode_ev || inc_ev || state_next != state)
      timeout_cnt <= '0;
    else
      timeout_cnt <= timeout_cnt + TW'(1);
  end

  // Blink phase restarts on each entry to hours so the first field always blinks identically.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_q   <= 1'b0;
    end else if (state == ST_IDLE && state_next == ST_SET_HH) begin
      blink_cnt <= '0;
      blink_q   <= 1'b0;
    end else if (editing) begin
      if (blink_cnt == BL_LAST) begin
        blink_cnt <= '0;
        blink_q   <= ~blink_q;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end else begin
      blink_cnt <= '0;
      blink_q   <= 1'b0;
    end
  end

  assign blink = blink_q & editing;

endmodule

// File: tb/tb_time_set_entry.sv
// Scoreboard bench for time_set_entry: a clock-time model predicts every
// commit (checked by a load monitor) and the edited fields after each press.
module tb_time_set_entry;

  localparam int DB = 4;
  localparam int TO = 64;
  localparam int BL = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_mode, key_inc;
  logic [7:0] hh_in, mm_in, ss_in;
  logic       pm_in;
  logic [7:0] hh_out, mm_out, ss_out;
  logic       pm_out, load, editing, blink;
  logic [1:0] field;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       pm;
  } snap_t;
  snap_t expq[$];

  int m_h, m_m, m_s, m_field;
  bit m_pm;

  always #5 clk = ~clk;

  time_set_entry #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO), .BLINK_CYCLES(BL)) dut (
    .clk(clk), .reset(reset), .key_mode(key_mode), .key_inc(key_inc),
    .hh_in(hh_in), .mm_in(mm_in), .ss_in(ss_in), .pm_in(pm_in),
    .hh_out(hh_out), .mm_out(mm_out), .ss_out(ss_out), .pm_out(pm_out),
    .load(load), .editing(editing), .field(field), .blink(blink)
  );

  function automatic int bcd_val(input logic [7:0] b);
    if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return -1;
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic checkVal(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void modelReset();
    m_h = 12; m_m = 0; m_s = 0; m_pm = 1'b0; m_field = 0;
  endfunction

  function automatic void modelMode();
    int v;
    case (m_field)
      0: begin
        v = bcd_val(hh_in); m_h = (v >= 1 && v <= 12) ? v : 12;
        v = bcd_val(mm_in); m_m = (v >= 0 && v <= 59) ? v : 0;
        v = bcd_val(ss_in); m_s = (v >= 0 && v <= 59) ? v : 0;
        m_pm = pm_in;
        m_field = 1;
      end
      1, 2: m_field++;
      default: begin
        expq.push_back('{to_bcd(m_h), to_bcd(m_m), to_bcd(m_s), m_pm});
        m_field = 0;
      end
    endcase
  endfunction

  function automatic void modelInc();
    case (m_field)
      1: begin
        if (m_h == 11) m_pm = !m_pm;
        m_h = m_h % 12 + 1;
      end
      2: m_m = (m_m + 1) % 60;
      3: m_s = (m_s + 1) % 60;
      default: ;
    endcase
  endfunction

  // Load monitor: every pulse must match the oldest predicted commit.
  logic load_prev = 1'b0;
  always @(negedge clk) begin
    snap_t e;
    if (load) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_load: got load=1 expected none at %0t", $time);
      end else begin
        e = expq.pop_front();
        checkVal("commit_hh", hh_out, e.hh);
        checkVal("commit_mm", mm_out, e.mm);
        checkVal("commit_ss", ss_out, e.ss);
        checkVal("commit_pm", pm_out, e.pm);
      end
      checkVal("load_width", load_prev, 0);
    end
    load_prev = load;
  end

  task automatic applyStimulus(input bit doMode, input bit doInc, input int holdCycles);
    if (holdCycles >= DB) begin
      if (doMode)     modelMode();
      else if (doInc) modelInc();
    end
    @(negedge clk);
    key_mode = doMode;
    key_inc  = doInc;
    repeat (holdCycles) @(negedge clk);
    key_mode = 1'b0;
    key_inc  = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, "_hh"}, hh_out, to_bcd(m_h));
    checkVal({tag, "_mm"}, mm_out, to_bcd(m_m));
    checkVal({tag, "_ss"}, ss_out, to_bcd(m_s));
    checkVal({tag, "_pm"}, pm_out, m_pm);
    checkVal({tag, "_field"}, field, m_field);
    checkVal({tag, "_editing"}, editing, m_field != 0);
    checkVal({tag, "_load"}, load, 0);
    if (m_field == 0) checkVal({tag, "_blink"}, blink, 0);
  endtask

  task automatic setInputs(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input logic p);
    @(negedge clk);
    hh_in = h; mm_in = m; ss_in = s; pm_in = p;
  endtask

  function automatic logic [7:0] randHour();
    if ($urandom_range(3) == 0) return 8'($urandom);
    return to_bcd(int'($urandom_range(1, 12)));
  endfunction

  function automatic logic [7:0] rand60();
    if ($urandom_range(3) == 0) return 8'($urandom);
    return to_bcd(int'($urandom_range(0, 59)));
  endfunction

  initial begin
    int toggles;
    logic last_blink;
    bit glitched;
    reset = 1'b1; key_mode = 1'b0; key_inc = 1'b0;
    hh_in = 8'h00; mm_in = 8'h00; ss_in = 8'h00; pm_in = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset");

    // 11:59:30 AM -> 12:00:32 PM
    setInputs(8'h11, 8'h59, 8'h30, 1'b0);
    applyStimulus(1, 0, 8);
    toggles = 0;
    last_blink = blink;
    repeat (32) begin
      @(negedge clk);
      if (blink != last_blink) toggles++;
      last_blink = blink;
    end
    checkVal("blink_toggles", toggles, 32 / BL);
    applyStimulus(0, 1, 8);
    applyStimulus(1, 0, 8);
    applyStimulus(0, 1, 8);
    applyStimulus(1, 0, 8);
    applyStimulus(0, 1, 8);
    applyStimulus(0, 1, 8);
    checkVal("plan_hh", hh_out, 8'h12);
    checkVal("plan_mm", mm_out, 8'h00);
    checkVal("plan_ss", ss_out, 8'h32);
    checkVal("plan_pm", pm_out, 1);
    applyStimulus(1, 0, 8);
    checkOutput("plan_commit");

    // 12 wraps to 01 without pm change; 59 wraps to 00; then timeout in SET_MM
    setInputs(8'h12, 8'h59, 8'h00, 1'b0);
    applyStimulus(1, 0, 8);
    applyStimulus(0, 1, 8);
    checkOutput("hour_wrap");
    applyStimulus(1, 0, 8);
    applyStimulus(0, 1, 8);
    checkOutput("min_wrap");
    repeat (30) @(negedge clk);
    checkOutput("before_timeout");
    repeat (40) @(negedge clk);
    m_field = 0;
    checkOutput("timeout");

    // Glitch rejection, single increment for a long hold, mode beats inc
    applyStimulus(1, 0, 8);
    applyStimulus(0, 1, 2);
    checkOutput("glitch");
    applyStimulus(0, 1, 10);
    checkOutput("long_hold");
    applyStimulus(1, 1, 8);
    checkOutput("mode_wins");
    applyStimulus(1, 0, 8);
    checkOutput("in_ss");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    checkOutput("reset_in_ss");

    // Randomised sessions
    for (int sess = 0; sess < 14; sess++) begin
      setInputs(randHour(), rand60(), rand60(), 1'($urandom));
      if ($urandom_range(2) == 0) applyStimulus(0, 1, int'($urandom_range(5, 9)));
      applyStimulus(1, 0, int'($urandom_range(5, 9)));
      checkOutput("rnd_enter");
      for (int f = 1; f <= 3; f++) begin
        glitched = 1'b0;
        for (int n = int'($urandom_range(0, 4)); n > 0; n--) begin
          if (!glitched && $urandom_range(3) == 0) begin
            applyStimulus(0, 1, int'($urandom_range(1, DB - 1)));
            glitched = 1'b1;
          end
          applyStimulus(0, 1, int'($urandom_range(5, 9)));
        end
        checkOutput("rnd_field");
        if (f < 3) applyStimulus(1, 0, int'($urandom_range(5, 9)));
      end
      if ($urandom_range(3) == 0) begin
        repeat (80) @(negedge clk);
        m_field = 0;
        checkOutput("rnd_timeout");
      end else begin
        applyStimulus(1, 0, int'($urandom_range(5, 9)));
        checkOutput("rnd_commit");
      end
    end

    repeat (20) @(negedge clk);
    checkVal("queue_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/time_set_entry.md
# time_set_entry

User-side time-setting front end for the traffic-light controller's 12-hour BCD clock. It debounces two raw push-buttons and lets the operator step through hours, minutes and seconds, incrementing each field in BCD. It presents the edited time, with the blink/field indication feeding the seven-segment path, and issues a one-cycle load pulse so the clock takes the new value. It sits between the board switches/keys and the clock's load port, on the opposite side of the clock from the display driver.

## Interface
- DEBOUNCE_CYCLES, 4, consecutive stable cycles (post-synchroniser) before a key level is accepted
- TIMEOUT_CYCLES, 64, cycles without a key event in an edit state before the edit is abandoned
- BLINK_CYCLES, 8, half-period of the blink output while editing
- clk  in  1  single clock; all logic is on its rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- key_mode  in  1  raw button, asynchronous; advances the field
- key_inc  in  1  raw button, asynchronous; increments the current field
- hh_in, mm_in, ss_in  in  8 each  current clock time, packed BCD
- pm_in  in  1  current clock PM flag
- hh_out, mm_out, ss_out  out  8 each  edited time, packed BCD
- pm_out  out  1  edited PM flag
- load  out  1  one-cycle pulse: clock loads *_out
- editing  out  1  high in SET_HH/SET_MM/SET_SS
- field  out  2  0 idle, 1 hours, 2 minutes, 3 seconds
- blink  out  1  toggles every BLINK_CYCLES while editing; 0 otherwise

## Operation
- Each key uses a 2-FF synchroniser followed by a debouncer. Any sample equal to the accepted level clears the counter. The accepted level changes after DEBOUNCE_CYCLES consecutive differing samples. A press event is a one-cycle pulse on a 0→1 transition of the accepted level. Release produces no event.
- The FSM has five states: IDLE, SET_HH, SET_MM, SET_SS, COMMIT.
- IDLE + mode event: capture hh_in/mm_in/ss_in/pm_in into the *_out registers, then go to SET_HH.
- SET_HH → SET_MM → SET_SS on mode events.
- SET_SS + mode event: go to COMMIT.
- COMMIT asserts load for exactly one cycle, then returns to IDLE unconditionally.
- Inc event in SET_HH:
  - 12→01.
  - 11→12 and toggles pm_out.
  - Otherwise the value is a BCD +1 (09→10).
- Inc event in SET_MM or SET_SS: BCD +1 over 00..59, with 59→00. No carry into other fields.
- Inc events in IDLE or COMMIT are ignored.
- If mode and inc events arrive in the same cycle, mode wins and inc is discarded.
- Timeout counter:
  - Cleared on entry to any SET_* state and on every key event.
  - At TIMEOUT_CYCLES the FSM goes to IDLE, load stays 0, and *_out keep their edited values.
- Out-of-range captured inputs are legal. Hours outside 01..12 load as 12. Minutes or seconds above 59 load as 00.
- field and editing are decoded from the state. blink is 0 whenever not editing, and its counter restarts at every entry to SET_HH.

## Timing
- Reset values:
  - State IDLE.
  - hh_out 8'h12, mm_out 8'h00, ss_out 8'h00, pm_out 0.
  - load 0, editing 0, field 0, blink 0.
  - Debouncer accepted levels 0; all counters 0.
- Reset mid-edit or mid-COMMIT: IDLE on the next edge, no load pulse.
- Event latency: a raw key rising before edge k and held produces its press event in the cycle after edge k+1+DEBOUNCE_CYCLES.
- The state and *_out effect of an event is visible after the following edge.
- With DEBOUNCE_CYCLES=4: event in the cycle after edge k+5, effect after edge k+6.
- load rises the cycle after the SET_SS mode event is registered and stays high for one cycle. hh_out/mm_out/ss_out/pm_out are stable during load and for at least the following cycle.
- A glitch shorter than DEBOUNCE_CYCLES samples produces no event.

## Structure
- Shared package tlc_pkg holds:
  - The FSM state encoding.
  - FIELD_IDLE/HH/MM/SS codes.
  - BCD constants 8'h12, 8'h59, 8'h01, 8'h00.
- Sub-module key_debounce (synchroniser + counter + edge detect, parameter DEBOUNCE_CYCLES) is instanced once per key.
- BCD increment is a local function per field type inside time_set_entry.

## Test plan
- Reset held 3 cycles, then released → hh_out=12, mm_out=00, ss_out=00, pm_out=0, load=0, field=0.
- Inputs 11:59:30 AM; sequence mode, inc, mode, inc, mode, inc, inc, mode → load pulse once with hh_out=12, mm_out=00, ss_out=32, pm_out=1.
- Hours 12 + inc → 01 with pm unchanged; minutes 59 + inc → 00 with hours unchanged.
- key_inc raw glitch of 2 cycles (DEBOUNCE_CYCLES=4) → no change; held 10 cycles → exactly one increment.
- mode and inc pressed in the same cycle in SET_HH → field=2, hh_out unchanged.
- Enter SET_MM, no keys for 64 cycles → IDLE, no load; separately, reset during SET_SS → IDLE next edge with no load.
